// File: rtl/maxpool2_relu_stream.sv
// 2x2 stride-2 max-pool + optional ReLU over a raster-order signed pixel stream.
// Latency: pooled pixel registered 1 cycle after the odd-row/odd-col input pixel.
// Backpressure: none; bubbles on valid_i freeze all state, downstream always accepts.
module maxpool2_relu_stream #(
    parameter int IN_W    = 24,
    parameter int DW      = 12,
    parameter bit RELU_EN = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          frame_done_o,
    output logic          busy_o
);

    localparam int OUT_W = IN_W / 2;
    localparam int CW    = $clog2(IN_W);
    localparam int LW    = CW - 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(IN_W - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [CW-1:0]        row_q, row_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [DW-1:0]        data_q, data_d;
    logic signed [DW-1:0] pair_q, pair_d;

    // One horizontal max per output column, held from the even row to the odd row.
    logic signed [DW-1:0] lbuf_q [OUT_W];
    logic                 lbuf_we;
    logic [LW-1:0]        lbuf_idx;
    logic signed [DW-1:0] lbuf_rd;

    logic signed [DW-1:0] pix;
    logic signed [DW-1:0] hmax;
    logic signed [DW-1:0] vmax;
    logic signed [DW-1:0] pooled;
    logic                 col_last;
    logic                 row_last;

    always_comb begin
        pix      = signed'(data_i);
        lbuf_idx = col_q[CW-1:1];
        lbuf_rd  = lbuf_q[lbuf_idx];
        hmax     = (pix > pair_q) ? pix : pair_q;
        vmax     = (lbuf_rd > hmax) ? lbuf_rd : hmax;
        pooled   = (RELU_EN && vmax[DW-1]) ? '0 : vmax;
        col_last = (col_q == LAST_IDX);
        row_last = (row_q == LAST_IDX);
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        data_d  = data_q;
        busy_d  = busy_q;
        lbuf_we = 1'b0;

        // Abort wins over a pixel presented in the same cycle.
        if (clear_i) begin
            col_d  = '0;
            row_d  = '0;
            pair_d = '0;
            data_d = '0;
            busy_d = 1'b0;
        end else if (valid_i) begin
            busy_d = 1'b1;
            if (!col_q[0]) begin
                pair_d = pix;
            end else if (!row_q[0]) begin
                lbuf_we = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = pooled;
            end

            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d  = '0;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    // Contents are always rewritten on an even row before being read, so no reset.
    always_ff @(posedge clk_i) begin
        if (lbuf_we) begin
            lbuf_q[lbuf_idx] <= hmax;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign frame_done_o = done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_maxpool2_relu_stream.sv
// Directed bench for maxpool2_relu_stream: one RELU_EN=1 and one RELU_EN=0 instance on shared inputs.
module tb_maxpool2_relu_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        vin;
    logic [11:0] din;
    logic        vo0, fd0, bz0, vo1, fd1, bz1;
    logic [11:0] do0, do1;

    int total = 0;
    int bad   = 0;

    logic [11:0] frame [576];
    logic [11:0] out_q [$];
    logic [11:0] out1_q [$];
    int          done_q [$];
    int          timing_err = 0;
    bit          exp_vld = 1'b0;
    bit          exp_done = 1'b0;
    int          tcol = 0;
    int          trow = 0;

    always #5 clk = ~clk;

    maxpool2_relu_stream #(.IN_W(24), .DW(12), .RELU_EN(1'b1)) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(vin), .data_i(din),
        .valid_o(vo0), .data_o(do0), .frame_done_o(fd0), .busy_o(bz0)
    );

    maxpool2_relu_stream #(.IN_W(24), .DW(12), .RELU_EN(1'b0)) dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(vin), .data_i(din),
        .valid_o(vo1), .data_o(do1), .frame_done_o(fd1), .busy_o(bz1)
    );

    always @(negedge clk) begin
        if (vo0 === 1'b1) out_q.push_back(do0);
        if (vo1 === 1'b1) out1_q.push_back(do1);
        if (fd0 === 1'b1) done_q.push_back(out_q.size());
        if (vo0 !== exp_vld || fd0 !== exp_done || vo1 !== exp_vld) timing_err++;
    end

    // Drives one cycle and records which output flags the next sample must show.
    task automatic drive(input bit v, input logic [11:0] d, input bit c);
        bit hit;
        bit last;
        hit  = 1'b0;
        last = 1'b0;
        vin  = v;
        din  = d;
        clr  = c;
        if (c) begin
            tcol = 0;
            trow = 0;
        end else if (v) begin
            hit  = (tcol % 2 == 1) && (trow % 2 == 1);
            last = hit && tcol == 23 && trow == 23;
            if (tcol == 23) begin
                tcol = 0;
                trow = (trow == 23) ? 0 : trow + 1;
            end else begin
                tcol = tcol + 1;
            end
        end
        @(posedge clk);
        #1;
        exp_vld  = hit;
        exp_done = last;
    endtask

    task automatic clear_logs();
        out_q.delete();
        out1_q.delete();
        done_q.delete();
        timing_err = 0;
    endtask

    task automatic load_ramp(input int off);
        for (int i = 0; i < 576; i++) frame[i] = 12'(i + off);
    endtask

    task automatic send_frame(input bit bubbles);
        for (int i = 0; i < 576; i++) begin
            int gap;
            gap = 0;
            if (bubbles) begin
                gap = i % 2;
                if ($urandom_range(0, 7) == 0) gap += $urandom_range(1, 4);
                if ((i / 32) % 3 == 2) gap = 0;
            end
            for (int g = 0; g < gap; g++) drive(1'b0, 12'h5A5, 1'b0);
            drive(1'b1, frame[i], 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 12'h000, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; vin = 1'b0; din = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        total++; if (vo0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", vo0); end
        total++; if (do0 !== 12'h000) begin bad++; $display("FAIL reset_data got=%h want=000", do0); end
        total++; if (fd0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", fd0); end
        total++; if (bz0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bz0); end
        rst = 1'b0;
        tcol = 0; trow = 0;
        idle(2);
        clear_logs();
    endtask

    task automatic test_ramp();
        clear_logs();
        load_ramp(0);
        for (int i = 0; i < 576; i++) begin
            drive(1'b1, frame[i], 1'b0);
            if (i == 0) begin
                total++; if (bz0 !== 1'b1) begin bad++; $display("FAIL ramp_busy_start got=%b want=1", bz0); end
            end
        end
        idle(3);
        total++; if (out_q.size() != 144) begin bad++; $display("FAIL ramp_count got=%0d want=144", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 144; i++) begin
            total++;
            if (out_q[i] !== 12'(48 * (i / 12) + 2 * (i % 12) + 25)) begin
                bad++; $display("FAIL ramp_out[%0d] got=%0d want=%0d", i, out_q[i], 48 * (i / 12) + 2 * (i % 12) + 25);
            end
        end
        total++; if (done_q.size() != 1 || done_q[0] != 144) begin bad++; $display("FAIL ramp_done pulses=%0d want 1 at output 144", done_q.size()); end
        total++; if (timing_err != 0) begin bad++; $display("FAIL ramp_timing errors=%0d want=0", timing_err); end
        total++; if (bz0 !== 1'b0) begin bad++; $display("FAIL ramp_busy_end got=%b want=0", bz0); end
    endtask

    task automatic test_negative();
        clear_logs();
        for (int i = 0; i < 576; i++) frame[i] = 12'hFFB;
        send_frame(1'b0);
        idle(2);
        total++; if (out_q.size() != 144 || out1_q.size() != 144) begin bad++; $display("FAIL neg_count got=%0d/%0d want=144/144", out_q.size(), out1_q.size()); end
        for (int i = 0; i < out_q.size() && i < out1_q.size() && i < 144; i++) begin
            total++; if (out_q[i] !== 12'h000) begin bad++; $display("FAIL neg_relu[%0d] got=%h want=000", i, out_q[i]); end
            total++; if (out1_q[i] !== 12'hFFB) begin bad++; $display("FAIL neg_norelu[%0d] got=%h want=ffb", i, out1_q[i]); end
        end
        total++; if (timing_err != 0) begin bad++; $display("FAIL neg_timing errors=%0d want=0", timing_err); end
    endtask

    task automatic test_window_pos();
        logic [11:0] e0 [144];
        logic [11:0] e1 [144];
        clear_logs();
        for (int i = 0; i < 576; i++) frame[i] = 12'h000;
        for (int k = 0; k < 144; k++) begin
            int r, c, pos, kind, idx;
            r = k / 12; c = k % 12; pos = k % 4; kind = (k / 4) % 4;
            idx = (2 * r + pos / 2) * 24 + 2 * c + pos % 2;
            case (kind)
                0: begin frame[idx] = 12'd100; e0[k] = 12'd100; e1[k] = 12'd100; end
                1: begin frame[idx] = 12'h7FF; e0[k] = 12'h7FF; e1[k] = 12'h7FF; end
                2: begin frame[idx] = 12'h800; e0[k] = 12'h000; e1[k] = 12'h000; end
                default: begin
                    for (int p = 0; p < 4; p++) frame[(2 * r + p / 2) * 24 + 2 * c + p % 2] = 12'h800;
                    e0[k] = 12'h000; e1[k] = 12'h800;
                end
            endcase
        end
        send_frame(1'b0);
        idle(2);
        total++; if (out_q.size() != 144 || out1_q.size() != 144) begin bad++; $display("FAIL win_count got=%0d/%0d want=144/144", out_q.size(), out1_q.size()); end
        for (int i = 0; i < out_q.size() && i < out1_q.size() && i < 144; i++) begin
            total++; if (out_q[i] !== e0[i]) begin bad++; $display("FAIL win_relu[%0d] got=%h want=%h", i, out_q[i], e0[i]); end
            total++; if (out1_q[i] !== e1[i]) begin bad++; $display("FAIL win_norelu[%0d] got=%h want=%h", i, out1_q[i], e1[i]); end
        end
    endtask

    task automatic test_bubbles();
        clear_logs();
        load_ramp(0);
        send_frame(1'b1);
        idle(3);
        total++; if (out_q.size() != 144) begin bad++; $display("FAIL bub_count got=%0d want=144", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 144; i++) begin
            total++;
            if (out_q[i] !== 12'(48 * (i / 12) + 2 * (i % 12) + 25)) begin
                bad++; $display("FAIL bub_out[%0d] got=%0d want=%0d", i, out_q[i], 48 * (i / 12) + 2 * (i % 12) + 25);
            end
        end
        total++; if (timing_err != 0) begin bad++; $display("FAIL bub_timing errors=%0d want=0", timing_err); end
        total++; if (done_q.size() != 1) begin bad++; $display("FAIL bub_done pulses=%0d want=1", done_q.size()); end
    endtask

    task automatic test_abort();
        load_ramp(0);
        for (int i = 0; i < 300; i++) drive(1'b1, frame[i], 1'b0);
        total++; if (bz0 !== 1'b1) begin bad++; $display("FAIL rst_busy_before got=%b want=1", bz0); end
        #2;
        rst = 1'b1;
        exp_vld = 1'b0; exp_done = 1'b0;
        #1;
        total++; if (vo0 !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b want=0", vo0); end
        total++; if (bz0 !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b want=0", bz0); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tcol = 0; trow = 0;
        idle(1);
        clear_logs();
        send_frame(1'b0);
        idle(2);
        total++; if (out_q.size() != 144) begin bad++; $display("FAIL rst_count got=%0d want=144", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 144; i++) begin
            total++;
            if (out_q[i] !== 12'(48 * (i / 12) + 2 * (i % 12) + 25)) begin
                bad++; $display("FAIL rst_out[%0d] got=%0d want=%0d", i, out_q[i], 48 * (i / 12) + 2 * (i % 12) + 25);
            end
        end

        // Abort 3 pixels into row 1 so stale state would corrupt the next frame.
        for (int i = 0; i < 27; i++) drive(1'b1, 12'h7FF, 1'b0);
        drive(1'b1, 12'h7FF, 1'b1);
        total++; if (bz0 !== 1'b0 || vo0 !== 1'b0) begin bad++; $display("FAIL clr_flags busy=%b valid=%b want 0/0", bz0, vo0); end
        total++; if (do0 !== 12'h000) begin bad++; $display("FAIL clr_data got=%h want=000", do0); end
        clear_logs();
        send_frame(1'b0);
        idle(2);
        total++; if (out_q.size() != 144) begin bad++; $display("FAIL clr_count got=%0d want=144", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 144; i++) begin
            total++;
            if (out_q[i] !== 12'(48 * (i / 12) + 2 * (i % 12) + 25)) begin
                bad++; $display("FAIL clr_out[%0d] got=%0d want=%0d", i, out_q[i], 48 * (i / 12) + 2 * (i % 12) + 25);
            end
        end
        total++; if (timing_err != 0) begin bad++; $display("FAIL clr_timing errors=%0d want=0", timing_err); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        load_ramp(0);
        send_frame(1'b0);
        load_ramp(1000);
        send_frame(1'b0);
        idle(3);
        total++; if (out_q.size() != 288) begin bad++; $display("FAIL b2b_count got=%0d want=288", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 288; i++) begin
            int j, off;
            j = i % 144;
            off = (i < 144) ? 25 : 1025;
            total++;
            if (out_q[i] !== 12'(48 * (j / 12) + 2 * (j % 12) + off)) begin
                bad++; $display("FAIL b2b_out[%0d] got=%0d want=%0d", i, out_q[i], 48 * (j / 12) + 2 * (j % 12) + off);
            end
        end
        total++;
        if (done_q.size() != 2 || done_q[0] != 144 || done_q[1] != 288) begin
            bad++; $display("FAIL b2b_done pulses=%0d want 2 at outputs 144,288", done_q.size());
        end
        total++; if (timing_err != 0) begin bad++; $display("FAIL b2b_timing errors=%0d want=0", timing_err); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_window_pos();
        test_bubbles();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
